// File: rtl/baccarat_pkg.sv
// Shared encodings and widths for the baccarat datapath.
package baccarat_pkg;

    localparam int unsigned BAL_W = 8;
    localparam int unsigned PAY_W = 12;

    // Wager side as presented on the switches.
    typedef enum logic [1:0] {
        BET_NONE   = 2'b00,
        BET_PLAYER = 2'b01,
        BET_DEALER = 2'b10,
        BET_TIE    = 2'b11
    } bet_side_e;

    // Outcome as {player_win_light, dealer_win_light}.
    typedef enum logic [1:0] {
        OUT_INVALID = 2'b00,
        OUT_DEALER  = 2'b01,
        OUT_PLAYER  = 2'b10,
        OUT_TIE     = 2'b11
    } outcome_e;

    // bet_bank round-tracking states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LOCKED = 2'b01,
        ST_ARMED  = 2'b10
    } bank_state_e;

endpackage

// File: rtl/bet_bank_if.sv
// Wager/outcome inputs and bankroll outputs between the game FSM and bet_bank.
interface bet_bank_if;
    import baccarat_pkg::*;

    logic [BAL_W-1:0] bet_amount;
    logic [1:0]       bet_side;
    logic             betenabled;
    logic             updatebalanceenable;
    logic             player_win_light;
    logic             dealer_win_light;
    logic [BAL_W-1:0] balance;
    logic [BAL_W-1:0] stake;
    logic             bet_clamped;
    logic             settled;

    modport master (
        output bet_amount, bet_side, betenabled, updatebalanceenable,
               player_win_light, dealer_win_light,
        input  balance, stake, bet_clamped, settled
    );

    modport slave (
        input  bet_amount, bet_side, betenabled, updatebalanceenable,
               player_win_light, dealer_win_light,
        output balance, stake, bet_clamped, settled
    );
endinterface

// File: rtl/dffr.sv
// Parameterised flipflop, asynchronous active-low reset to RST_VAL.
module dffr #(
    parameter int unsigned   W       = 1,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clock,
    input  logic         resetb,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    // Register with async reset.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) q <= RST_VAL;
        else         q <= d;
    end
endmodule

// File: rtl/payout_calc.sv
// Combinational payout for a settled round: total returned to the bankroll.
module payout_calc
    import baccarat_pkg::*;
#(
    parameter int unsigned TIE_MULT = 9
) (
    input  bet_side_e         side,
    input  outcome_e          outcome,
    input  logic [BAL_W-1:0]  stake,
    output logic [PAY_W-1:0]  payout_c
);
    logic [PAY_W-1:0] stake_w;
    logic [PAY_W-1:0] double_w;
    logic [PAY_W-1:0] commission_w;
    logic [PAY_W-1:0] tie_w;

    assign stake_w      = PAY_W'(stake);
    assign double_w     = stake_w << 1;
    assign commission_w = PAY_W'(stake / 8'd20);
    assign tie_w        = PAY_W'(TIE_MULT) * stake_w;

    // Select payout by side and outcome; an invalid outcome refunds the stake.
    always_comb begin
        payout_c = '0;
        if (side == BET_NONE) begin
            payout_c = '0;
        end else if (outcome == OUT_INVALID) begin
            payout_c = stake_w;
        end else begin
            unique case (side)
                BET_PLAYER: begin
                    if (outcome == OUT_PLAYER)   payout_c = double_w;
                    else if (outcome == OUT_TIE) payout_c = stake_w;
                end
                BET_DEALER: begin
                    if (outcome == OUT_DEALER)   payout_c = double_w - commission_w;
                    else if (outcome == OUT_TIE) payout_c = stake_w;
                end
                BET_TIE: begin
                    if (outcome == OUT_TIE)      payout_c = tie_w;
                end
                default: payout_c = '0;
            endcase
        end
    end
endmodule

// File: rtl/bet_bank.sv
// Wager escrow and bankroll: lock the stake at bet time, settle after the outcome.
module bet_bank
    import baccarat_pkg::*;
#(
    parameter logic [BAL_W-1:0] INIT_BALANCE = 8'd100,
    parameter int unsigned      TIE_MULT     = 9
) (
    input  logic       clock,
    input  logic       resetb,
    bet_bank_if.slave  bus
);
    bank_state_e      state_q, state_d;
    logic [1:0]       state_raw_q;
    logic [BAL_W-1:0] balance_q, balance_d;
    logic [BAL_W-1:0] stake_q, stake_d;
    bet_side_e        side_q, side_d;
    logic             clamped_q, clamped_d;
    logic             settled_q, settled_d;

    outcome_e         outcome_c;
    logic [PAY_W-1:0] payout_c;
    logic [PAY_W-1:0] sum_c;

    dffr #(.W(2), .RST_VAL(2'(ST_IDLE))) u_state_reg (
        .clock  (clock),
        .resetb (resetb),
        .d      (2'(state_d)),
        .q      (state_raw_q)
    );
    assign state_q = bank_state_e'(state_raw_q);

    assign outcome_c = outcome_e'({bus.player_win_light, bus.dealer_win_light});

    payout_calc #(.TIE_MULT(TIE_MULT)) u_payout (
        .side     (side_q),
        .outcome  (outcome_c),
        .stake    (stake_q),
        .payout_c (payout_c)
    );

    assign sum_c = PAY_W'(balance_q) + payout_c;

    // Next-state and datapath updates for bet lock and settlement.
    always_comb begin
        state_d   = state_q;
        balance_d = balance_q;
        stake_d   = stake_q;
        side_d    = side_q;
        clamped_d = clamped_q;
        settled_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.betenabled) begin
                    side_d = bet_side_e'(bus.bet_side);
                    if (bet_side_e'(bus.bet_side) == BET_NONE) begin
                        stake_d   = '0;
                        clamped_d = 1'b0;
                    end else if (bus.bet_amount > balance_q) begin
                        stake_d   = balance_q;
                        clamped_d = 1'b1;
                    end else begin
                        stake_d   = bus.bet_amount;
                        clamped_d = 1'b0;
                    end
                    balance_d = balance_q - stake_d;
                    state_d   = ST_LOCKED;
                end
            end
            // Outcome may still change on this edge (third dealer card), so only arm.
            ST_LOCKED: begin
                if (bus.updatebalanceenable) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                balance_d = (sum_c > PAY_W'({BAL_W{1'b1}})) ? {BAL_W{1'b1}}
                                                             : sum_c[BAL_W-1:0];
                stake_d   = '0;
                clamped_d = 1'b0;
                settled_d = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath registers; reset discards any escrowed stake.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            balance_q <= INIT_BALANCE;
            stake_q   <= '0;
            side_q    <= BET_NONE;
            clamped_q <= 1'b0;
            settled_q <= 1'b0;
        end else begin
            balance_q <= balance_d;
            stake_q   <= stake_d;
            side_q    <= side_d;
            clamped_q <= clamped_d;
            settled_q <= settled_d;
        end
    end

    assign bus.balance     = balance_q;
    assign bus.stake       = stake_q;
    assign bus.bet_clamped = clamped_q;
    assign bus.settled     = settled_q;
endmodule

// File: tb/tb_bet_bank.sv
// Randomised round-level checks of bet_bank against a bankroll model.
module tb_bet_bank;
    import baccarat_pkg::*;

    logic clock  = 1'b0;
    logic resetb = 1'b0;
    always #5 clock = ~clock;

    bet_bank_if bif();

    bet_bank #(.INIT_BALANCE(8'd100), .TIE_MULT(9)) dut (
        .clock  (clock),
        .resetb (resetb),
        .bus    (bif.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int m_balance;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Total returned to the bankroll, from the published payout table.
    function automatic int ref_payout(input int side, input int outc, input int stk);
        if (side == 0) return 0;
        if (outc == 0) return stk;
        case (side)
            1: return (outc == 2) ? 2 * stk : (outc == 3) ? stk : 0;
            2: return (outc == 1) ? 2 * stk - stk / 20 : (outc == 3) ? stk : 0;
            3: return (outc == 3) ? 9 * stk : 0;
            default: return 0;
        endcase
    endfunction

    task automatic clear_inputs();
        bif.bet_amount          = '0;
        bif.bet_side            = 2'b00;
        bif.betenabled          = 1'b0;
        bif.updatebalanceenable = 1'b0;
        bif.player_win_light    = 1'b0;
        bif.dealer_win_light    = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        resetb = 1'b0;
        #12;
        check("rst_balance", int'(bif.balance), 100);
        check("rst_stake", int'(bif.stake), 0);
        check("rst_clamped", int'(bif.bet_clamped), 0);
        check("rst_settled", int'(bif.settled), 0);
        @(negedge clock);
        resetb = 1'b1;
        m_balance = 100;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One full round; noise adds ignored strobes in IDLE, LOCKED and ARMED.
    task automatic run_round(input int amt, input int side, input int outc, input bit noise);
        int exp_stake, exp_clamp, pay;
        if (noise) begin
            bif.updatebalanceenable = 1'b1;
            tick();
            bif.updatebalanceenable = 1'b0;
            check("idle_ube_balance", int'(bif.balance), m_balance);
            check("idle_ube_settled", int'(bif.settled), 0);
        end
        exp_stake = (side == 0) ? 0 : ((amt < m_balance) ? amt : m_balance);
        exp_clamp = (side != 0 && amt > m_balance) ? 1 : 0;
        m_balance = m_balance - exp_stake;

        bif.bet_amount = 8'(amt);
        bif.bet_side   = 2'(side);
        bif.betenabled = 1'b1;
        tick();
        if (noise) bif.bet_amount = 8'($urandom);
        else       bif.betenabled = 1'b0;
        check("lock_stake", int'(bif.stake), exp_stake);
        check("lock_balance", int'(bif.balance), m_balance);
        check("lock_clamped", int'(bif.bet_clamped), exp_clamp);

        repeat ($urandom_range(1, 3)) tick();
        check("hold_balance", int'(bif.balance), m_balance);
        check("hold_stake", int'(bif.stake), exp_stake);

        bif.updatebalanceenable = 1'b1;
        tick();
        bif.betenabled = 1'b0;
        if (!noise) bif.updatebalanceenable = 1'b0;
        bif.player_win_light = outc[1];
        bif.dealer_win_light = outc[0];
        check("armed_balance", int'(bif.balance), m_balance);
        check("armed_settled", int'(bif.settled), 0);

        tick();
        bif.updatebalanceenable = 1'b0;
        pay = ref_payout(side, outc, exp_stake);
        m_balance = (m_balance + pay > 255) ? 255 : m_balance + pay;
        check("settle_balance", int'(bif.balance), m_balance);
        check("settle_stake", int'(bif.stake), 0);
        check("settle_clamped", int'(bif.bet_clamped), 0);
        check("settle_pulse", int'(bif.settled), 1);

        bif.player_win_light = 1'b0;
        bif.dealer_win_light = 1'b0;
        tick();
        check("post_settled", int'(bif.settled), 0);
        check("post_balance", int'(bif.balance), m_balance);
    endtask

    initial begin
        clear_inputs();

        do_reset();
        run_round(30, 1, 2, 1'b0);
        check("tp_player_win", int'(bif.balance), 130);

        do_reset();
        run_round(40, 2, 1, 1'b0);
        check("tp_dealer_win", int'(bif.balance), 138);

        do_reset();
        run_round(200, 3, 3, 1'b0);
        check("tp_tie_saturate", int'(bif.balance), 255);

        do_reset();
        run_round(50, 1, 3, 1'b1);
        check("tp_push", int'(bif.balance), 100);
        run_round(20, 2, 0, 1'b0);
        check("tp_refund", int'(bif.balance), 100);
        run_round(10, 0, 2, 1'b0);
        check("tp_no_bet", int'(bif.balance), 100);

        // Reset while armed with a 70 stake in escrow.
        do_reset();
        bif.bet_amount = 8'd70;
        bif.bet_side   = 2'b01;
        bif.betenabled = 1'b1;
        tick();
        bif.betenabled = 1'b0;
        check("mid_lock_balance", int'(bif.balance), 30);
        bif.updatebalanceenable = 1'b1;
        tick();
        bif.updatebalanceenable = 1'b0;
        bif.player_win_light = 1'b1;
        #2;
        resetb = 1'b0;
        #1;
        check("mid_rst_balance", int'(bif.balance), 100);
        check("mid_rst_stake", int'(bif.stake), 0);
        check("mid_rst_settled", int'(bif.settled), 0);
        tick();
        check("mid_rst_hold_settled", int'(bif.settled), 0);
        @(negedge clock);
        resetb = 1'b1;
        bif.player_win_light = 1'b0;
        m_balance = 100;
        tick();
        check("mid_rst_no_pulse", int'(bif.settled), 0);
        check("mid_rst_after_balance", int'(bif.balance), 100);
        run_round(10, 1, 2, 1'b0);
        check("mid_rst_next_round", int'(bif.balance), 110);

        // Random rounds.
        repeat (60) begin
            if (m_balance < 10) do_reset();
            run_round(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
